// File: rtl/ctrl_branch_sequencer_pkg.sv
// rtl/ctrl_branch_sequencer_pkg.sv - shared state/request encodings for the branch sequencer
package ctrl_branch_sequencer_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Redirect request kinds. Halt is handled separately because it is
    // never a redirect: it is deferred behind any redirect of the same cycle.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_BR   = 2'd1,
        REQ_CALL = 2'd2,
        REQ_RET  = 2'd3
    } req_e;

    // Redirect priority: return over call over branch
    function automatic req_e pick_req(input logic ret, input logic call, input logic br);
        if (ret)
            return REQ_RET;
        else if (call)
            return REQ_CALL;
        else if (br)
            return REQ_BR;
        else
            return REQ_NONE;
    endfunction

endpackage

// File: rtl/ctrl_ret_stack.sv
// rtl/ctrl_ret_stack.sv - small LIFO return-address stack
module ctrl_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WID   = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [WID-1:0] din,
    output logic [WID-1:0] dout,
    output logic           full,
    output logic           empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]    count;
    logic [WID-1:0] mem [DEPTH];
    logic [AW-1:0]  top_idx;

    // DEPTH is a power of two, so the low bits of count wrap naturally
    assign top_idx = count[AW-1:0] - AW'(1);
    assign dout    = mem[top_idx];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[count[AW-1:0]] <= din;
    end

    // Occupancy; overflowing pushes and underflowing pops are dropped
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (push && !full)
            count <= count + (AW+1)'(1);
        else if (pop && !empty)
            count <= count - (AW+1)'(1);
    end

endmodule

// File: rtl/ctrl_branch_sequencer.sv
// rtl/ctrl_branch_sequencer.sv - PC redirect sequencer with flush window, halt and RAS
module ctrl_branch_sequencer
    import ctrl_branch_sequencer_pkg::*;
#(
    parameter int PROG_CTR_WID = 10,
    parameter int FLUSH_DEPTH  = 2,
    parameter int RAS_DEPTH    = 4,
    parameter int RESET_VEC    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_in,
    input  logic                    ex_valid,
    input  logic [PROG_CTR_WID-1:0] ex_pc,
    input  logic                    br_req,
    input  logic                    call_req,
    input  logic                    ret_req,
    input  logic [PROG_CTR_WID-1:0] br_target,
    input  logic                    halt_req,
    input  logic                    resume,
    output logic                    redirect,
    output logic [PROG_CTR_WID-1:0] redirect_pc,
    output logic                    pc_hold,
    output logic                    invalidate,
    output logic                    halted,
    output logic                    ras_ovf,
    output logic                    ras_unf
);
    localparam logic [2:0]              FD   = 3'(FLUSH_DEPTH);
    localparam logic [PROG_CTR_WID-1:0] RVEC = PROG_CTR_WID'(RESET_VEC);

    state_e                  state;
    logic [2:0]              flush_cnt;
    logic                    halt_pend;

    req_e                    req_sel;
    logic                    accept;
    logic                    ras_push;
    logic                    ras_pop;
    logic [PROG_CTR_WID-1:0] ras_top;
    logic                    ras_full;
    logic                    ras_empty;
    logic [PROG_CTR_WID-1:0] push_val;
    logic [PROG_CTR_WID-1:0] target;

    // Only instructions issued in RUN on an unstalled cycle may redirect
    assign req_sel  = pick_req(ret_req, call_req, br_req);
    assign accept   = (state == ST_RUN) && ex_valid && !stall_in && (req_sel != REQ_NONE);
    assign push_val = ex_pc + PROG_CTR_WID'(1);
    assign ras_push = accept && (req_sel == REQ_CALL) && !ras_full;
    assign ras_pop  = accept && (req_sel == REQ_RET) && !ras_empty;

    // Redirect destination for the accepted request
    always_comb begin
        target = br_target;
        if (req_sel == REQ_RET)
            target = ras_empty ? RVEC : ras_top;
    end

    // PC may only load on the redirect cycle while flushing
    assign pc_hold = stall_in | halted | ((state == ST_FLUSH) && !redirect);

    ctrl_ret_stack #(
        .DEPTH (RAS_DEPTH),
        .WID   (PROG_CTR_WID)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (push_val),
        .dout  (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    // Sequencer FSM with registered redirect, flush window and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            flush_cnt   <= '0;
            halt_pend   <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= RVEC;
            invalidate  <= 1'b0;
            halted      <= 1'b0;
            ras_ovf     <= 1'b0;
            ras_unf     <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        state       <= ST_FLUSH;
                        flush_cnt   <= FD;
                        halt_pend   <= halt_req;
                        redirect    <= 1'b1;
                        redirect_pc <= target;
                        invalidate  <= 1'b1;
                        if (req_sel == REQ_RET && ras_empty)
                            ras_unf <= 1'b1;
                        if (req_sel == REQ_CALL && ras_full)
                            ras_ovf <= 1'b1;
                    end else if (halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // A halt seen during the window waits for the window to close
                    halt_pend <= halt_pend | halt_req;
                    if (!stall_in) begin
                        if (flush_cnt <= 3'd1) begin
                            flush_cnt  <= '0;
                            invalidate <= 1'b0;
                            halt_pend  <= 1'b0;
                            if (halt_pend || halt_req) begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume && !halt_req) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
